reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
- Board-level reset generator between the clock manager's LOCKED output and the game core(s).
- Replaces the single inverted-LOCKED reset with a parametrised, lock-filtered, multi-stage sequencer.
- Releases NUM_STAGES reset outputs in order (e.g. memories, CPU, video, PS/2) after a hold period.
- Re-asserts all of them on lock loss and reports a sticky lock-lost flag.

Parameters:
- NUM_STAGES, 3, number of sequenced reset outputs (1..8).
- LOCK_FILTER, 8, consecutive synchronised-high LOCKED samples required before lock is accepted (>=1).
- HOLD_CYCLES, 1024, cycles all stages stay in reset after lock is accepted (>=1).
- STAGE_GAP, 16, cycles between successive stage releases (>=1).
- LOCK_TIMEOUT_CYCLES, 2**20, watchdog limit; used only with the optional feature.

Ports:
- CLK_25MHZ  in  1  system clock.
- RESET  in  1  synchronous, active-high global reset.
- LOCKED  in  1  clock-manager lock; asynchronous to CLK_25MHZ.
- STAGE_RESET  out  NUM_STAGES  active-high resets; bit 0 is released first.
- READY  out  1  high when every stage is out of reset.
- LOCK_LOST  out  1  sticky; lock dropped after it had been accepted.
- STATE  out  2  0=WAIT_LOCK, 1=HOLD, 2=RELEASE, 3=RUN.
- LOCK_TIMEOUT  out  1  watchdog flag (optional feature).

Behaviour:
- Reset (RESET=1 at an edge):
  - state WAIT_LOCK; STAGE_RESET all ones; READY=0; LOCK_LOST=0; LOCK_TIMEOUT=0.
  - Both synchroniser flops, the filter counter and the hold/gap counters are set to 0.
  - RESET overrides every other event in the same cycle.
- Synchroniser: two flops on LOCKED; downstream logic uses only the second flop (lock_s).
- Filter:
  - lock_f rises after LOCK_FILTER consecutive cycles of lock_s=1.
  - Any lock_s=0 clears the counter and drops lock_f on the next edge, with no filtering on loss.
- WAIT_LOCK: when lock_f=1, go to HOLD and clear the hold counter.
- HOLD:
  - Count HOLD_CYCLES cycles.
  - On the terminal edge, go to RELEASE and deassert STAGE_RESET[0] on that same edge.
- RELEASE:
  - Every STAGE_GAP cycles, deassert the next bit in ascending order.
  - On the edge that clears bit NUM_STAGES-1, go to RUN and set READY=1.
  - NUM_STAGES=1: go HOLD→RUN directly; bit 0 and READY change on the same edge.
- RUN: hold outputs until lock loss.
- Timing, counting the first edge that samples LOCKED=1 as edge 1 (LOCKED held high):
  - STAGE_RESET[0] falls at edge E0 = 3 + LOCK_FILTER + HOLD_CYCLES.
  - Bit k falls at edge E0 + k*STAGE_GAP.
  - READY rises with the last bit.
- Lock loss (lock_f=0 while in HOLD, RELEASE or RUN):
  - On the next edge, STAGE_RESET goes to all ones, READY=0, state WAIT_LOCK, counters cleared, LOCK_LOST=1.
  - The full filter, hold and release sequence is repeated on relock.
- LOCK_LOST clears only on RESET.
- Lock loss in the same cycle as a stage release: loss wins, and that stage is not released.
- Counter widths: $clog2(max value + 1); no wrap within a phase, because each counter clears on every state entry.
- Outputs are registered; no combinational path from LOCKED to any output.

Optional Feature:
- Macro: RESET_SEQ_WATCHDOG_EN.
- Defined:
  - A counter runs while in WAIT_LOCK and clears on leaving it.
  - Reaching LOCK_TIMEOUT_CYCLES sets LOCK_TIMEOUT=1, sticky until RESET.
  - The sequencer keeps waiting; STAGE_RESET stays all ones.
- Undefined: no watchdog logic; LOCK_TIMEOUT is tied to 0.

Decomposition:
- Shared package reset_seq_pkg holds:
  - the state enum (WAIT_LOCK, HOLD, RELEASE, RUN) with its 2-bit encoding;
  - the default parameter constants.
- One natural sub-module, lock_filter: the two-flop synchroniser plus consecutive-sample filter, producing lock_f.

Test Plan:
- NUM_STAGES=3, LOCK_FILTER=4, HOLD_CYCLES=8, STAGE_GAP=2; RESET pulse, then LOCKED=1 from edge 1 -> STAGE_RESET goes 111→110 at edge 15, 100 at edge 17, 000 at edge 19; READY=1 at edge 19; STATE reads 3 afterwards.
- Same config; LOCKED glitches high for 3 cycles, then low -> stays in WAIT_LOCK, STAGE_RESET=111, LOCK_LOST=0.
- In RUN, drop LOCKED for 1 cycle -> 3 edges after the drop is sampled, STAGE_RESET=111, READY=0, LOCK_LOST=1; on relock the full sequence repeats with LOCK_LOST still 1.
- Drop LOCKED so that lock_f falls in the cycle stage 1 would release -> STAGE_RESET returns to 111 and bit 1 never clears.
- Assert RESET in RELEASE with STAGE_RESET=100 -> next edge all outputs at reset values; LOCK_LOST=0.
- With RESET_SEQ_WATCHDOG_EN and LOCK_TIMEOUT_CYCLES=50, LOCKED held low -> LOCK_TIMEOUT=1 after 50 cycles in WAIT_LOCK; without the macro it stays 0.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared state encoding and default parameters for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  localparam int DEF_NUM_STAGES          = 3;
  localparam int DEF_LOCK_FILTER         = 8;
  localparam int DEF_HOLD_CYCLES         = 1024;
  localparam int DEF_STAGE_GAP           = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 2 ** 20;

endpackage

// File: rtl/lock_filter.sv
// Two-flop synchroniser on LOCKED followed by a consecutive-high sample filter.
// Lock acceptance is filtered; lock loss propagates on the next edge unfiltered.
module lock_filter
  import reset_seq_pkg::*;
#(
  parameter int LOCK_FILTER = DEF_LOCK_FILTER
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_locked,
  output logic o_lock_f
);

  localparam int                 CNT_W    = $clog2(LOCK_FILTER + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(LOCK_FILTER - 1);

  logic             r_meta;
  logic             r_lock_s;
  logic             r_lock_f;
  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta   <= 1'b0;
      r_lock_s <= 1'b0;
      r_lock_f <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_meta   <= i_locked;
      r_lock_s <= r_meta;
      if (!r_lock_s) begin
        r_cnt    <= '0;
        r_lock_f <= 1'b0;
      end else if (r_cnt == CNT_LAST) begin
        r_lock_f <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_lock_f = r_lock_f;

endmodule

// File: rtl/reset_sequencer.sv
// Lock-filtered multi-stage reset sequencer; stage resets release in ascending order.
// Optional lock watchdog enabled by defining RESET_SEQ_WATCHDOG_EN.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES          = DEF_NUM_STAGES,
  parameter int LOCK_FILTER         = DEF_LOCK_FILTER,
  parameter int HOLD_CYCLES         = DEF_HOLD_CYCLES,
  parameter int STAGE_GAP           = DEF_STAGE_GAP,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES
) (
  input  logic                  CLK_25MHZ,
  input  logic                  RESET,
  input  logic                  LOCKED,
  output logic [NUM_STAGES-1:0] STAGE_RESET,
  output logic                  READY,
  output logic                  LOCK_LOST,
  output logic [1:0]            STATE,
  output logic                  LOCK_TIMEOUT
);

  if (NUM_STAGES < 1 || NUM_STAGES > 8 || LOCK_FILTER < 1 || HOLD_CYCLES < 1 ||
      STAGE_GAP < 1 || LOCK_TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("reset_sequencer: parameter out of range");
  end

  localparam int                HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam int                GAP_W     = $clog2(STAGE_GAP + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);

  logic w_lock_f;

  seq_state_e            r_state,       w_state_nxt;
  logic [NUM_STAGES-1:0] r_stage_reset, w_stage_nxt;
  logic                  r_ready,       w_ready_nxt;
  logic                  r_lock_lost,   w_lost_nxt;
  logic [HOLD_W-1:0]     r_hold_cnt,    w_hold_nxt;
  logic [GAP_W-1:0]      r_gap_cnt,     w_gap_nxt;
  logic [NUM_STAGES-1:0] w_released;

  lock_filter #(.LOCK_FILTER(LOCK_FILTER)) u_lock_filter (
    .i_clk    (CLK_25MHZ),
    .i_rst    (RESET),
    .i_locked (LOCKED),
    .o_lock_f (w_lock_f)
  );

  // Stage resets form a thermometer code, so releasing the next bit is a left shift.
  assign w_released = r_stage_reset << 1;

  // NOTE: defaults first so no path through this block infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_stage_nxt = r_stage_reset;
    w_ready_nxt = r_ready;
    w_lost_nxt  = r_lock_lost;
    w_hold_nxt  = r_hold_cnt;
    w_gap_nxt   = r_gap_cnt;

    if (r_state != WAIT_LOCK && !w_lock_f) begin
      w_state_nxt = WAIT_LOCK;
      w_stage_nxt = '1;
      w_ready_nxt = 1'b0;
      w_lost_nxt  = 1'b1;
      w_hold_nxt  = '0;
      w_gap_nxt   = '0;
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          if (w_lock_f) begin
            w_state_nxt = HOLD;
            w_hold_nxt  = '0;
          end
        end
        HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            w_stage_nxt = w_released;
            w_gap_nxt   = '0;
            if (w_released == '0) begin
              w_state_nxt = RUN;
              w_ready_nxt = 1'b1;
            end else begin
              w_state_nxt = RELEASE;
            end
          end else begin
            w_hold_nxt = r_hold_cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (r_gap_cnt == GAP_LAST) begin
            w_stage_nxt = w_released;
            w_gap_nxt   = '0;
            if (w_released == '0) begin
              w_state_nxt = RUN;
              w_ready_nxt = 1'b1;
            end
          end else begin
            w_gap_nxt = r_gap_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK_25MHZ) begin
    if (RESET) begin
      r_state       <= WAIT_LOCK;
      r_stage_reset <= '1;
      r_ready       <= 1'b0;
      r_lock_lost   <= 1'b0;
      r_hold_cnt    <= '0;
      r_gap_cnt     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_stage_reset <= w_stage_nxt;
      r_ready       <= w_ready_nxt;
      r_lock_lost   <= w_lost_nxt;
      r_hold_cnt    <= w_hold_nxt;
      r_gap_cnt     <= w_gap_nxt;
    end
  end

`ifdef RESET_SEQ_WATCHDOG_EN
  localparam int              WD_W    = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(LOCK_TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_lock_timeout;

  always_ff @(posedge CLK_25MHZ) begin
    if (RESET) begin
      r_wd_cnt       <= '0;
      r_lock_timeout <= 1'b0;
    end else if (r_state != WAIT_LOCK) begin
      r_wd_cnt <= '0;
    end else if (r_wd_cnt == WD_LAST) begin
      r_lock_timeout <= 1'b1;
    end else begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  assign LOCK_TIMEOUT = r_lock_timeout;
`else
  assign LOCK_TIMEOUT = 1'b0;
`endif

  assign STAGE_RESET = r_stage_reset;
  assign READY       = r_ready;
  assign LOCK_LOST   = r_lock_lost;
  assign STATE       = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: stimulus queues cycle-tagged expectations, a negedge monitor compares.
module tb_reset_sequencer;

  localparam int NS = 3;
  localparam int LF = 4;
  localparam int HC = 8;
  localparam int SG = 2;
  localparam int TO = 50;

`ifdef RESET_SEQ_WATCHDOG_EN
  localparam logic WD_ON = 1'b1;
`else
  localparam logic WD_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          locked;
  logic [NS-1:0] stage_reset;
  logic          ready;
  logic          lock_lost;
  logic [1:0]    state;
  logic          lock_timeout;

  reset_sequencer #(
    .NUM_STAGES          (NS),
    .LOCK_FILTER         (LF),
    .HOLD_CYCLES         (HC),
    .STAGE_GAP           (SG),
    .LOCK_TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK_25MHZ    (clk),
    .RESET        (rst),
    .LOCKED       (locked),
    .STAGE_RESET  (stage_reset),
    .READY        (ready),
    .LOCK_LOST    (lock_lost),
    .STATE        (state),
    .LOCK_TIMEOUT (lock_timeout)
  );

  always #5 clk = ~clk;

  // Expected vector layout: {stage[2:0], ready, lock_lost, state[1:0], lock_timeout}
  typedef struct {
    int unsigned at;
    string       tag;
    logic [7:0]  exp;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  bit          stim_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void expect_at(input int unsigned at, input string tag,
                                    input logic [2:0] stg, input logic rdy,
                                    input logic lost, input logic [1:0] st,
                                    input logic to = 1'b0);
    exp_t e;
    e.at  = at;
    e.tag = tag;
    e.exp = {stg, rdy, lost, st, to};
    sb.push_back(e);
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @cyc %0d: got stg/rdy/lost/st/to=%b/%b/%b/%0d/%b want %b/%b/%b/%0d/%b",
               name, cyc, got[7:5], got[4], got[3], got[2:1], got[0],
               want[7:5], want[4], want[3], want[2:1], want[0]);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.at == cyc) begin
        check(mon_e.tag, {stage_reset, ready, lock_lost, state, lock_timeout}, mon_e.exp);
      end else begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cyc %0d not sampled (now %0d)", mon_e.tag, mon_e.at, cyc);
      end
    end
    if (stim_done) begin
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL sb_drained: got %0d pending, want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  task automatic wait_to(input int unsigned c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(output int unsigned r);
    rst = 1'b1;
    r   = cyc + 1;
    expect_at(r, "reset", 3'b111, 1'b0, 1'b0, 2'd0);
    wait_to(r);
    rst = 1'b0;
  endtask

  initial begin
    int unsigned c0, c1, d, r;
    rst    = 1'b1;
    locked = 1'b0;
    wait_to(2);

    // Full sequence: LOCKED high from edge c0+1, E0 = 3+4+8 = 15
    do_reset(c0);
    locked = 1'b1;
    expect_at(c0 + 14, "hold_end",  3'b111, 1'b0, 1'b0, 2'd1);
    expect_at(c0 + 15, "rel_bit0",  3'b110, 1'b0, 1'b0, 2'd2);
    expect_at(c0 + 16, "gap_bit0",  3'b110, 1'b0, 1'b0, 2'd2);
    expect_at(c0 + 17, "rel_bit1",  3'b100, 1'b0, 1'b0, 2'd2);
    expect_at(c0 + 18, "gap_bit1",  3'b100, 1'b0, 1'b0, 2'd2);
    expect_at(c0 + 19, "rel_bit2",  3'b000, 1'b1, 1'b0, 2'd3);
    expect_at(c0 + 26, "run_hold",  3'b000, 1'b1, 1'b0, 2'd3);
    wait_to(c0 + 26);

    // One-cycle lock drop in RUN, sampled at edge d; relock edge 1 is d+1
    locked = 1'b0;
    d = cyc + 1;
    wait_to(d);
    locked = 1'b1;
    expect_at(d + 2,  "loss_pipe",   3'b000, 1'b1, 1'b0, 2'd3);
    expect_at(d + 3,  "loss_reset",  3'b111, 1'b0, 1'b1, 2'd0);
    expect_at(d + 14, "relock_hold", 3'b111, 1'b0, 1'b1, 2'd1);
    expect_at(d + 15, "relock_b0",   3'b110, 1'b0, 1'b1, 2'd2);
    expect_at(d + 17, "relock_b1",   3'b100, 1'b0, 1'b1, 2'd2);
    expect_at(d + 19, "relock_b2",   3'b000, 1'b1, 1'b1, 2'd3);
    wait_to(d + 22);

    // Two 3-cycle glitches: filter must never accept lock
    do_reset(r);
    locked = 1'b1;
    expect_at(r + 6, "glitch1", 3'b111, 1'b0, 1'b0, 2'd0);
    wait_to(r + 3);
    locked = 1'b0;
    wait_to(r + 8);
    locked = 1'b1;
    wait_to(r + 11);
    locked = 1'b0;
    expect_at(r + 16, "glitch2",      3'b111, 1'b0, 1'b0, 2'd0);
    expect_at(r + 20, "glitch_final", 3'b111, 1'b0, 1'b0, 2'd0);
    wait_to(r + 20);

    // Loss lands on the stage-1 release edge (c0+17): loss wins
    do_reset(c0);
    locked = 1'b1;
    expect_at(c0 + 15, "race_b0",  3'b110, 1'b0, 1'b0, 2'd2);
    expect_at(c0 + 16, "race_gap", 3'b110, 1'b0, 1'b0, 2'd2);
    wait_to(c0 + 13);
    locked = 1'b0;
    expect_at(c0 + 17, "race_loss",  3'b111, 1'b0, 1'b1, 2'd0);
    expect_at(c0 + 19, "race_no_b1", 3'b111, 1'b0, 1'b1, 2'd0);
    expect_at(c0 + 24, "race_wait",  3'b111, 1'b0, 1'b1, 2'd0);
    wait_to(c0 + 24);

    // Relock with LOCK_LOST set, then RESET while STAGE_RESET=100
    c1 = cyc;
    locked = 1'b1;
    expect_at(c1 + 17, "pre_rst_100", 3'b100, 1'b0, 1'b1, 2'd2);
    wait_to(c1 + 17);
    rst = 1'b1;
    expect_at(c1 + 18, "rst_in_release", 3'b111, 1'b0, 1'b0, 2'd0);
    wait_to(c1 + 18);
    rst = 1'b0;
    expect_at(c1 + 32, "post_rst_hold", 3'b111, 1'b0, 1'b0, 2'd1);
    expect_at(c1 + 33, "post_rst_b0",   3'b110, 1'b0, 1'b0, 2'd2);
    wait_to(c1 + 34);

    // Watchdog: LOCKED held low for TO cycles in WAIT_LOCK
    locked = 1'b0;
    do_reset(r);
    expect_at(r + TO - 1, "wd_before", 3'b111, 1'b0, 1'b0, 2'd0, 1'b0);
    expect_at(r + TO,     "wd_at",     3'b111, 1'b0, 1'b0, 2'd0, WD_ON);
    expect_at(r + TO + 10, "wd_sticky", 3'b111, 1'b0, 1'b0, 2'd0, WD_ON);
    wait_to(r + TO + 12);

    stim_done = 1'b1;
  end

endmodule
